// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between instruction fetch and
//               data access. Data has priority, with a streak limit so fetch
//               is never starved, and a wait limit that aborts dead accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifValid,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [3:0]  dBe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        memReq,
  output logic        memWe,
  output logic [3:0]  memBe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  output logic        stallF,
  output logic        stallAll,
  output logic        timeoutErr
);

  localparam int STREAK_W = $clog2(STARVE_LIM + 1);
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIM);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [WAIT_W-1:0]   wait_cnt;

  logic if_elig;
  logic d_elig;
  logic fetch_starved;
  logic grant_d;
  logic grant_if;
  logic timeout_hit;

  // A requester in its valid cycle is still holding req for the finished access.
  assign if_elig       = ifReq & ~ifValid;
  assign d_elig        = dReq & ~dValid;
  assign fetch_starved = if_elig & (streak == STREAK_MAX);
  assign grant_d       = d_elig & ~fetch_starved;
  assign grant_if      = if_elig & ~grant_d;
  // An ack in the limit cycle completes normally rather than aborting.
  assign timeout_hit   = ~memAck & (wait_cnt == WAIT_LAST);

  assign stallAll = dReq & ~dValid;
  assign stallF   = stallAll | (ifReq & ~ifValid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      streak     <= '0;
      wait_cnt   <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memBe      <= 4'h0;
      memAddr    <= 32'h0;
      memWdata   <= 32'h0;
      ifRdata    <= 32'h0;
      dRdata     <= 32'h0;
      ifValid    <= 1'b0;
      dValid     <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      ifValid <= 1'b0;
      dValid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state    <= ST_DATA;
            memReq   <= 1'b1;
            memWe    <= dWe;
            memBe    <= dBe;
            memAddr  <= dAddr;
            memWdata <= dWdata;
            wait_cnt <= '0;
            if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_if) begin
            state    <= ST_IFETCH;
            memReq   <= 1'b1;
            memWe    <= 1'b0;
            memBe    <= 4'hF;
            memAddr  <= ifAddr;
            memWdata <= 32'h0;
            wait_cnt <= '0;
            streak   <= '0;
          end
        end
        ST_IFETCH, ST_DATA: begin
          if (memAck || timeout_hit) begin
            state  <= ST_IDLE;
            memReq <= 1'b0;
            if (timeout_hit) begin
              timeoutErr <= 1'b1;
            end
            if (state == ST_IFETCH) begin
              ifValid <= 1'b1;
              ifRdata <= memAck ? memRdata : 32'h0;
            end else begin
              dValid <= 1'b1;
              // Aborted accesses return zero; completed stores leave dRdata alone.
              if (!memAck) begin
                dRdata <= 32'h0;
              end else if (!memWe) begin
                dRdata <= memRdata;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized bench for mem_port_arbiter against a
//               behavioural per-cycle arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int STARVE_LIM = 4;
  localparam int MAX_WAIT   = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic [31:0] ifRdata;
  logic        ifValid;
  logic        dReq = 1'b0;
  logic        dWe = 1'b0;
  logic [3:0]  dBe = '0;
  logic [31:0] dAddr = '0;
  logic [31:0] dWdata = '0;
  logic [31:0] dRdata;
  logic        dValid;
  logic        memReq;
  logic        memWe;
  logic [3:0]  memBe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = '0;
  logic        memAck = 1'b0;
  logic        stallF;
  logic        stallAll;
  logic        timeoutErr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIM(STARVE_LIM), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifValid(ifValid),
    .dReq(dReq), .dWe(dWe), .dBe(dBe), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(dRdata), .dValid(dValid),
    .memReq(memReq), .memWe(memWe), .memBe(memBe), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck),
    .stallF(stallF), .stallAll(stallAll), .timeoutErr(timeoutErr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the memory, how long it has waited, the data streak.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_wait;
  int          m_streak;
  logic        m_err;
  logic        exp_ifv, exp_dv, exp_req, exp_we;
  logic [31:0] exp_ifr, exp_dr, exp_addr, exp_wd;
  logic [3:0]  exp_be;

  task automatic model_reset();
    m_owner = 0; m_wait = 0; m_streak = 0; m_err = 1'b0;
    exp_ifv = 1'b0; exp_dv = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_ifr = '0; exp_dr = '0; exp_addr = '0; exp_wd = '0; exp_be = '0;
  endtask

  task automatic model_step();
    logic nv_if, nv_d, want_i, want_d;
    nv_if  = 1'b0;
    nv_d   = 1'b0;
    want_i = ifReq && !exp_ifv;
    want_d = dReq && !exp_dv;
    if (m_owner == 0) begin
      if (want_d && !(want_i && m_streak == STARVE_LIM)) begin
        m_owner = 2; m_wait = 0;
        m_streak = (m_streak < STARVE_LIM) ? m_streak + 1 : STARVE_LIM;
        exp_req = 1'b1; exp_addr = dAddr; exp_we = dWe; exp_be = dBe; exp_wd = dWdata;
      end else if (want_i) begin
        m_owner = 1; m_wait = 0; m_streak = 0;
        exp_req = 1'b1; exp_addr = ifAddr; exp_we = 1'b0; exp_be = 4'hF; exp_wd = '0;
      end
    end else if (memAck || m_wait + 1 == MAX_WAIT) begin
      if (!memAck) m_err = 1'b1;
      if (m_owner == 1) begin
        nv_if = 1'b1;
        exp_ifr = memAck ? memRdata : 32'h0;
      end else begin
        nv_d = 1'b1;
        if (!memAck) exp_dr = 32'h0;
        else if (!exp_we) exp_dr = memRdata;
      end
      m_owner = 0;
      exp_req = 1'b0;
    end else begin
      m_wait++;
    end
    exp_ifv = nv_if;
    exp_dv  = nv_d;
  endtask

  // Stimulus knobs and memory responder state.
  int          p_if = 0, p_d = 0;
  int          ack_mode = -1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;
  bit          mem_armed = 1'b0;
  int          mem_cnt = 0, mem_delay = 0;

  task automatic drive_stim();
    int r;
    if (!ifReq || exp_ifv) begin
      ifReq = ($urandom_range(99) < p_if);
      if (ifReq) ifAddr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dReq || exp_dv) begin
      dReq = ($urandom_range(99) < p_d);
      if (dReq) begin
        dWe = $urandom_range(1); dBe = 4'($urandom); dAddr = $urandom; dWdata = $urandom;
      end
    end
    if (memReq) begin
      if (!mem_armed) begin
        mem_armed = 1'b1; mem_cnt = 0;
        if (ack_mode >= 0) mem_delay = ack_mode;
        else begin
          r = $urandom_range(99);
          mem_delay = (r < 40) ? 0 : (r < 70) ? 1 : (r < 85) ? $urandom_range(5, 2) :
                      (r < 93) ? MAX_WAIT - 1 : MAX_WAIT;
        end
      end
      memAck   = (mem_cnt == mem_delay);
      memRdata = use_fixed ? fixed_rdata : $urandom;
      mem_cnt++;
    end else begin
      mem_armed = 1'b0;
      memAck    = ($urandom_range(9) == 0);
      memRdata  = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check_eq("memReq", 32'(memReq), 32'(exp_req));
    if (exp_req) begin
      check_eq("memAddr", memAddr, exp_addr);
      check_eq("memWe", 32'(memWe), 32'(exp_we));
      check_eq("memBe", 32'(memBe), 32'(exp_be));
      check_eq("memWdata", memWdata, exp_wd);
    end
    check_eq("ifValid", 32'(ifValid), 32'(exp_ifv));
    check_eq("dValid", 32'(dValid), 32'(exp_dv));
    check_eq("ifRdata", ifRdata, exp_ifr);
    check_eq("dRdata", dRdata, exp_dr);
    check_eq("timeoutErr", 32'(timeoutErr), 32'(m_err));
    drive_stim();
    #1;
    check_eq("stallAll", 32'(stallAll), 32'(dReq & ~exp_dv));
    check_eq("stallF", 32'(stallF), 32'((dReq & ~exp_dv) | (ifReq & ~exp_ifv)));
  endtask

  // kind 0: ifValid, 1: dValid, 2: quiet (no requests, memory idle)
  task automatic run_until(input int kind, input int limit, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      cycle();
      hit = (kind == 0) ? ifValid : (kind == 1) ? dValid : (!memReq && !ifReq && !dReq);
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait expired after %0d cycles", tag, limit);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_memReq", 32'(memReq), 32'h0);
    check_eq("rst_memAddr", memAddr, 32'h0);
    check_eq("rst_ifValid", 32'(ifValid), 32'h0);
    check_eq("rst_dValid", 32'(dValid), 32'h0);
    check_eq("rst_timeoutErr", 32'(timeoutErr), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Fetch only with two wait cycles.
    ack_mode = 2; use_fixed = 1'b1; fixed_rdata = 32'hE3A01005;
    ifReq = 1'b1; ifAddr = 32'h100;
    run_until(0, 20, "fetch_wait");
    check_eq("fetch_rdata", ifRdata, 32'hE3A01005);

    // Simultaneous requests: data first, fetch right after dValid.
    run_until(2, 20, "quiet1");
    ack_mode = 1; fixed_rdata = 32'h1234_5678;
    ifReq = 1'b1; ifAddr = 32'h180;
    dReq = 1'b1; dWe = 1'b0; dBe = 4'hF; dAddr = 32'h200; dWdata = '0;
    cycle();
    check_eq("arb_data_first", memAddr, 32'h200);
    run_until(1, 20, "data_wait");
    cycle();
    check_eq("fetch_after_dvalid", memAddr, 32'h180);
    run_until(0, 20, "fetch2_wait");

    // Store leaves dRdata untouched.
    run_until(2, 20, "quiet2");
    dReq = 1'b1; dWe = 1'b1; dBe = 4'b0011; dAddr = 32'h300; dWdata = 32'hCAFEBABE;
    cycle();
    check_eq("store_we", 32'(memWe), 32'h1);
    check_eq("store_be", 32'(memBe), 32'h3);
    check_eq("store_wdata", memWdata, 32'hCAFEBABE);
    run_until(1, 20, "store_wait");
    check_eq("store_keeps_drdata", dRdata, 32'h1234_5678);

    // Streak limit: after four data grants a fresh fetch beats a fresh load.
    for (int i = 0; i < 4; i++) begin
      run_until(2, 20, "quiet_streak");
      dReq = 1'b1; dWe = 1'b0; dAddr = 32'h600 + 32'(4 * i);
      run_until(1, 20, "streak_load");
    end
    run_until(2, 20, "quiet3");
    ifReq = 1'b1; ifAddr = 32'h700;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h610;
    cycle();
    check_eq("starve_fetch_wins", memAddr, 32'h700);
    run_until(0, 20, "starve_fetch_wait");
    cycle();
    check_eq("data_resumes", memAddr, 32'h610);
    run_until(1, 20, "resume_wait");

    // Timeout: no ack ever arrives.
    run_until(2, 20, "quiet4");
    ack_mode = MAX_WAIT;
    ifReq = 1'b1; ifAddr = 32'h800;
    run_until(0, 40, "timeout_wait");
    check_eq("timeout_rdata", ifRdata, 32'h0);
    check_eq("timeout_err", 32'(timeoutErr), 32'h1);

    // Randomized traffic at several mixes.
    use_fixed = 1'b0; ack_mode = -1;
    p_if = 30; p_d = 70; repeat (2500) cycle();
    p_if = 60; p_d = 60; repeat (2500) cycle();
    p_if = 10; p_d = 90; repeat (2500) cycle();

    // Asynchronous reset in the middle of a data access.
    p_if = 0; p_d = 0;
    run_until(2, 60, "quiet5");
    ack_mode = 100;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h400;
    repeat (3) cycle();
    check_eq("rst_pre_memReq", 32'(memReq), 32'h1);
    reset = 1'b0;
    ifReq = 1'b0; dReq = 1'b0; memAck = 1'b0;
    #1;
    check_eq("rst_async_memReq", 32'(memReq), 32'h0);
    check_eq("rst_async_err", 32'(timeoutErr), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mem_armed = 1'b0;
    repeat (5) cycle();

    ack_mode = -1; p_if = 50; p_d = 50;
    repeat (1500) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
